// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter: ROB index width,
// producer source ids and the round-robin pointer advance helper.
package cdb_arbiter_pkg;

    // Width of a reorder-buffer index carried on the CDB.
    localparam int ROB_WIDTH_BIT = 5;

    // Width of a broadcast result value.
    localparam int CDB_DATA_W = 32;

    // Producer ids; the arbiter input slot number equals the source id.
    typedef enum logic [1:0] {
        CDB_SRC_ALU = 2'd0,
        CDB_SRC_LSB = 2'd1,
        CDB_SRC_BR  = 2'd2
    } cdbSrcE;

    // Index width needed to name one of n producers (at least one bit).
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Combinational round-robin picker: starting at the pointer and wrapping,
// returns the first occupied slot as a one-hot grant plus its index.
module rr_select
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDXW = idxWidth(NREQ)
) (
    input  logic [NREQ-1:0] occ,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grantIdx,
    output logic            anyGrant
);

    logic [IDXW-1:0] w_cand;

    // Walk the slots from ptr upward with wrap; first occupied slot wins.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        w_cand   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!anyGrant && occ[w_cand]) begin
                anyGrant      = 1'b1;
                grant[w_cand] = 1'b1;
                grantIdx      = w_cand;
            end
            w_cand = (w_cand == IDXW'(NREQ - 1)) ? '0 : w_cand + 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one single-entry buffer per result producer,
// round-robin selection of one buffered result per active cycle, and a
// registered broadcast of the winner. Supports pause, flush and reset.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int ROB_SIZE_BIT = ROB_WIDTH_BIT
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         clear,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*ROB_SIZE_BIT-1:0] req_rob_id,
    input  logic [NREQ*32-1:0]           req_val,
    output logic                         cdb_valid,
    output logic [ROB_SIZE_BIT-1:0]      cdb_rob_id,
    output logic [31:0]                  cdb_val,
    output logic [1:0]                   cdb_src
);

    localparam int IDXW = idxWidth(NREQ);

    logic [NREQ-1:0]         r_bufValid;
    logic [ROB_SIZE_BIT-1:0] r_bufRob [NREQ];
    logic [31:0]             r_bufVal [NREQ];
    logic [IDXW-1:0]         r_rrPtr;

    logic [NREQ-1:0]         w_rawGrant;
    logic [NREQ-1:0]         w_grant;
    logic [NREQ-1:0]         w_accept;
    logic [IDXW-1:0]         w_grantIdx;
    logic [IDXW-1:0]         w_nextPtr;
    logic                    w_rawAny;
    logic                    w_anyGrant;
    logic                    w_active;

    rr_select #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rrSelect (
        .occ      (r_bufValid),
        .ptr      (r_rrPtr),
        .grant    (w_rawGrant),
        .grantIdx (w_grantIdx),
        .anyGrant (w_rawAny)
    );

    // A cycle only moves data when out of reset, not paused and not flushing;
    // a granted buffer frees up in the same cycle so it can be refilled at once.
    assign w_active   = rst_in & rdy_in & ~clear;
    assign w_grant    = w_rawGrant & {NREQ{w_active}};
    assign w_anyGrant = w_rawAny & w_active;
    assign req_ready  = {NREQ{w_active}} & (~r_bufValid | w_grant);
    assign w_accept   = req_valid & req_ready;
    assign w_nextPtr  = (w_grantIdx == IDXW'(NREQ - 1)) ? '0 : w_grantIdx + 1'b1;

    // Per-producer buffers: load on accept (wins over a same-cycle grant), empty on grant or flush.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_bufValid <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_bufRob[i] <= '0;
                r_bufVal[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clear) begin
                r_bufValid <= '0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (w_accept[i]) begin
                        r_bufValid[i] <= 1'b1;
                        r_bufRob[i]   <= req_rob_id[i*ROB_SIZE_BIT +: ROB_SIZE_BIT];
                        r_bufVal[i]   <= req_val[i*32 +: 32];
                    end else if (w_grant[i]) begin
                        r_bufValid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Broadcast register and round-robin pointer; payload holds when nothing is granted.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_rrPtr    <= '0;
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_val    <= '0;
            cdb_src    <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                r_rrPtr   <= '0;
                cdb_valid <= 1'b0;
            end else if (w_anyGrant) begin
                r_rrPtr    <= w_nextPtr;
                cdb_valid  <= 1'b1;
                cdb_rob_id <= r_bufRob[w_grantIdx];
                cdb_val    <= r_bufVal[w_grantIdx];
                cdb_src    <= 2'(w_grantIdx);
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single producer, contention,
// flush, back-pressure, pause and mid-stream reset with hand-computed values.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NREQ = 3;
    localparam int RW   = ROB_WIDTH_BIT;

    logic                 clk_in;
    logic                 rst_in;
    logic                 rdy_in;
    logic                 clear;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*RW-1:0]   req_rob_id;
    logic [NREQ*32-1:0]   req_val;
    logic                 cdb_valid;
    logic [RW-1:0]        cdb_rob_id;
    logic [31:0]          cdb_val;
    logic [1:0]           cdb_src;

    int totalCount;
    int badCount;

    cdb_arbiter #(
        .NREQ         (NREQ),
        .ROB_SIZE_BIT (RW)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rob_id (req_rob_id),
        .req_val    (req_val),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_val    (cdb_val),
        .cdb_src    (cdb_src)
    );

    // Free-running 10-unit clock.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Compare one observed value against its expectation and tally it.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic stepClock();
        @(posedge clk_in);
        #1;
    endtask

    // Load the data slice of one producer.
    task automatic setProducer(input int i, input logic [RW-1:0] rob, input logic [31:0] val);
        req_rob_id[i*RW +: RW] = rob;
        req_val[i*32 +: 32]    = val;
    endtask

    // Drive the control inputs for the coming edge.
    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy, input logic clr);
        req_valid = valid;
        rdy_in    = rdy;
        clear     = clr;
    endtask

    // Check a full broadcast beat.
    task automatic checkCdb(input string tag, input logic [RW-1:0] rob, input logic [31:0] val, input logic [1:0] src);
        checkOutput({tag, "_valid"}, 64'(cdb_valid), 64'd1);
        checkOutput({tag, "_rob"}, 64'(cdb_rob_id), 64'(rob));
        checkOutput({tag, "_val"}, 64'(cdb_val), 64'(val));
        checkOutput({tag, "_src"}, 64'(cdb_src), 64'(src));
    endtask

    initial begin
        logic [2:0] expReady;
        totalCount = 0;
        badCount   = 0;
        rst_in     = 1'b0;
        req_rob_id = '0;
        req_val    = '0;
        applyStimulus(3'b111, 1'b1, 1'b0);
        #1;
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        stepClock();
        stepClock();
        checkOutput("rst_valid", 64'(cdb_valid), 64'd0);
        checkOutput("rst_rob", 64'(cdb_rob_id), 64'd0);
        checkOutput("rst_val", 64'(cdb_val), 64'd0);
        checkOutput("rst_src", 64'(cdb_src), 64'd0);
        rst_in = 1'b1;
        applyStimulus(3'b000, 1'b1, 1'b0);
        stepClock();
        checkOutput("idle_valid", 64'(cdb_valid), 64'd0);

        // Single LSB result.
        setProducer(1, 5'd5, 32'h1234);
        applyStimulus(3'b010, 1'b1, 1'b0);
        #1;
        checkOutput("single_ready", 64'(req_ready), 64'b111);
        stepClock();
        applyStimulus(3'b000, 1'b1, 1'b0);
        checkOutput("single_lat", 64'(cdb_valid), 64'd0);
        stepClock();
        checkCdb("single", 5'd5, 32'h1234, 2'(CDB_SRC_LSB));
        stepClock();
        checkOutput("single_end", 64'(cdb_valid), 64'd0);

        // Flush an idle arbiter to return the pointer to 0.
        applyStimulus(3'b000, 1'b1, 1'b1);
        #1;
        checkOutput("clr_ready", 64'(req_ready), 64'd0);
        stepClock();
        applyStimulus(3'b000, 1'b1, 1'b0);

        // Three-way contention, grant order 0,1,2,0,1,2.
        for (int i = 0; i < NREQ; i++) setProducer(i, RW'(10 + i), 32'hA0 + 32'(i));
        applyStimulus(3'b111, 1'b1, 1'b0);
        stepClock();
        checkOutput("cont_ready0", 64'(req_ready), 64'b001);
        for (int k = 0; k < 6; k++) begin
            stepClock();
            checkCdb("cont", RW'(10 + k % 3), 32'hA0 + 32'(k % 3), 2'(k % 3));
            expReady = 3'b001 << ((k + 1) % 3);
            checkOutput("cont_ready", 64'(req_ready), 64'(expReady));
        end

        // Flush with all buffers full, then an ALU result right after.
        applyStimulus(3'b111, 1'b1, 1'b1);
        #1;
        checkOutput("flush_ready", 64'(req_ready), 64'd0);
        stepClock();
        checkOutput("flush_valid", 64'(cdb_valid), 64'd0);
        setProducer(0, 5'd7, 32'h77);
        applyStimulus(3'b001, 1'b1, 1'b0);
        #1;
        checkOutput("flush_empty", 64'(req_ready), 64'b111);
        stepClock();
        applyStimulus(3'b000, 1'b1, 1'b0);
        checkOutput("flush_lat", 64'(cdb_valid), 64'd0);
        stepClock();
        checkCdb("flush_alu", 5'd7, 32'h77, 2'(CDB_SRC_ALU));
        stepClock();
        checkOutput("flush_end", 64'(cdb_valid), 64'd0);

        // Back-pressure: pointer is 1, so producer 0 waits behind 1 and 2.
        setProducer(0, 5'd20, 32'h200);
        setProducer(1, 5'd21, 32'h210);
        setProducer(2, 5'd22, 32'h220);
        applyStimulus(3'b111, 1'b1, 1'b0);
        stepClock();
        applyStimulus(3'b000, 1'b1, 1'b0);
        #1;
        checkOutput("bp_ready_a", 64'(req_ready), 64'b010);
        stepClock();
        checkCdb("bp_1", 5'd21, 32'h210, 2'd1);
        checkOutput("bp_ready_b", 64'(req_ready), 64'b110);
        stepClock();
        checkCdb("bp_2", 5'd22, 32'h220, 2'd2);
        checkOutput("bp_ready_c", 64'(req_ready), 64'b111);
        stepClock();
        checkCdb("bp_0", 5'd20, 32'h200, 2'd0);
        stepClock();
        checkOutput("bp_nodup", 64'(cdb_valid), 64'd0);

        // Pause with a grant pending for producer 0 while branch result is on the bus.
        setProducer(0, 5'd3, 32'h33);
        setProducer(2, 5'd9, 32'h99);
        applyStimulus(3'b101, 1'b1, 1'b0);
        stepClock();
        applyStimulus(3'b000, 1'b1, 1'b0);
        stepClock();
        checkCdb("pause_pre", 5'd9, 32'h99, 2'(CDB_SRC_BR));
        applyStimulus(3'b001, 1'b0, 1'b0);
        #1;
        checkOutput("pause_ready", 64'(req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            stepClock();
            checkCdb("pause_hold", 5'd9, 32'h99, 2'(CDB_SRC_BR));
        end
        applyStimulus(3'b000, 1'b1, 1'b0);
        stepClock();
        checkCdb("pause_done", 5'd3, 32'h33, 2'(CDB_SRC_ALU));
        stepClock();
        checkOutput("pause_end", 64'(cdb_valid), 64'd0);

        // Reset mid-stream while a result is on the bus and two are buffered.
        setProducer(0, 5'd1, 32'h11);
        setProducer(1, 5'd2, 32'h22);
        setProducer(2, 5'd4, 32'h44);
        applyStimulus(3'b111, 1'b1, 1'b0);
        stepClock();
        applyStimulus(3'b000, 1'b1, 1'b0);
        stepClock();
        checkCdb("mid_pre", 5'd2, 32'h22, 2'd1);
        rst_in = 1'b0;
        #1;
        checkOutput("mid_ready", 64'(req_ready), 64'd0);
        stepClock();
        checkOutput("mid_valid", 64'(cdb_valid), 64'd0);
        checkOutput("mid_rob", 64'(cdb_rob_id), 64'd0);
        checkOutput("mid_val", 64'(cdb_val), 64'd0);
        checkOutput("mid_src", 64'(cdb_src), 64'd0);
        rst_in = 1'b1;
        stepClock();
        checkOutput("post_rst_a", 64'(cdb_valid), 64'd0);
        stepClock();
        checkOutput("post_rst_b", 64'(cdb_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
